// File: rtl/afb_pkg.sv
// Shared definitions for the audio frame buffer: register map, bit positions,
// capture state encoding and a sign-extension helper.
package afb_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_ACK    = 2;
    localparam int REG_FILL   = 3;
    localparam int REG_DROPS  = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_READY     = 0;
    localparam int ST_OVF       = 1;
    localparam int ST_READ_BANK = 2;
    localparam int ST_MASK_LSB  = 8;

    localparam logic [15:0] DROPS_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } cap_state_e;

    // Replicates bit w-1 of v into every bit above it.
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/afb_sample_ram.sv
// Two-bank sample store: one memory per channel so a whole stream beat is
// written in a single cycle; read port has one cycle of latency.
module afb_sample_ram
    import afb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 256,
    parameter int S_W      = $clog2(DEPTH),
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic                         wr_bank,
    input  logic [S_W-1:0]               wr_sample,
    input  logic [CHANNELS*DATA_W-1:0]   wr_data,
    input  logic                         rd_en,
    input  logic                         rd_bank,
    input  logic [S_W-1:0]               rd_sample,
    input  logic [CH_W-1:0]              rd_ch,
    output logic [DATA_W-1:0]            rd_data
);

    logic [DATA_W-1:0] rd_word_q [CHANNELS];
    logic [CH_W-1:0]   rd_ch_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DATA_W-1:0] mem [2*DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[{wr_bank, wr_sample}] <= wr_data[gi*DATA_W +: DATA_W];
                end
                if (rd_en) begin
                    rd_word_q[gi] <= mem[{rd_bank, rd_sample}];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_ch_q <= rd_ch;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_W'(c) == rd_ch_q) begin
                rd_data = rd_word_q[c];
            end
        end
    end

endmodule

// File: rtl/audio_frame_buffer_avalon.sv
// Avalon-MM slave capturing a multi-channel sample stream into ping-pong
// frame banks, with a CPU read window plus control/status/IRQ registers.
module audio_frame_buffer_avalon
    import afb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(CHANNELS*DEPTH) + 1
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        snk_valid,
    input  logic [CHANNELS*DATA_W-1:0]  snk_data,
    output logic                        snk_ready,
    input  logic [ADDR_W-1:0]           avs_address,
    input  logic                        avs_read,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    output logic [31:0]                 avs_readdata,
    output logic                        avs_waitrequest,
    output logic                        irq
);

    localparam int S_W   = $clog2(DEPTH);
    localparam int IDX_W = ADDR_W - 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    cap_state_e        state_q, state_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       drops_q, drops_d;
    logic [1:0]        ready_q, ready_d;
    logic              rd_bank_q, rd_bank_d;
    logic              cap_bank_q, cap_bank_d;
    logic [S_W-1:0]    fill_q, fill_d;
    logic              irq_q, irq_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_win_q, rd_win_d;
    logic [31:0]       rd_reg_q, rd_reg_d;

    logic              win_sel;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  win_ch_full;
    logic              win_in_range;
    logic [S_W-1:0]    win_sample;
    logic [CH_W-1:0]   win_ch;
    int                reg_off;
    logic              wr_ctrl, wr_ack, wr_drops, ack_ok;
    logic [1:0]        ready_a;
    logic              ram_we, drop, rd_start;
    logic [31:0]       status;
    logic [DATA_W-1:0] ram_rd_data;
    logic              unused_wdata;

    assign win_sel      = avs_address[ADDR_W-1];
    assign win_idx      = avs_address[IDX_W-1:0];
    assign win_sample   = win_idx[S_W-1:0];
    assign win_ch_full  = win_idx >> S_W;
    assign win_in_range = (win_ch_full < IDX_W'(CHANNELS));
    assign win_ch       = CH_W'(win_ch_full);
    assign reg_off      = int'(win_idx);
    assign unused_wdata = ^avs_writedata[31:2];

    assign wr_ctrl  = avs_write && !win_sel && (reg_off == REG_CTRL);
    assign wr_ack   = avs_write && !win_sel && (reg_off == REG_ACK);
    assign wr_drops = avs_write && !win_sel && (reg_off == REG_DROPS);
    assign ack_ok   = wr_ack && ready_q[rd_bank_q];

    // The release is applied before any bank completion in the same cycle.
    always_comb begin
        ready_a = ready_q;
        if (ack_ok) begin
            ready_a[rd_bank_q] = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        cap_bank_d = cap_bank_q;
        ready_d    = ready_a;
        ram_we     = 1'b0;
        drop       = 1'b0;
        case (state_q)
            IDLE: begin
                fill_d = '0;
                if (ctrl_q[CTRL_EN]) begin
                    if (!ready_a[cap_bank_q]) begin
                        state_d = FILL;
                    end else if (!ready_a[~cap_bank_q]) begin
                        cap_bank_d = ~cap_bank_q;
                        state_d    = FILL;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            FILL: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = IDLE;
                    fill_d  = '0;
                end else if (snk_valid) begin
                    ram_we = 1'b1;
                    if (fill_q == S_W'(DEPTH - 1)) begin
                        ready_d[cap_bank_q] = 1'b1;
                        fill_d              = '0;
                        if (!ready_a[~cap_bank_q]) begin
                            cap_bank_d = ~cap_bank_q;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            STALL: begin
                fill_d = '0;
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = IDLE;
                end else begin
                    drop = snk_valid;
                    if (ack_ok) begin
                        state_d    = FILL;
                        cap_bank_d = rd_bank_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fill_d  = '0;
            end
        endcase
    end

    // Keep the read pointer on a ready bank whenever one exists.
    always_comb begin
        rd_bank_d = rd_bank_q;
        if (!ready_d[rd_bank_q] && ready_d[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (wr_ctrl) begin
            ctrl_d = avs_writedata[1:0];
        end
        if (wr_drops) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != DROPS_MAX) begin
                drops_d = drops_q + 16'd1;
            end
        end
        irq_d = ctrl_q[CTRL_IRQ_EN] && ready_q[rd_bank_q];
    end

    always_comb begin
        status                  = '0;
        status[ST_READY]        = ready_q[rd_bank_q];
        status[ST_OVF]          = ovf_q;
        status[ST_READ_BANK]    = rd_bank_q;
        status[ST_MASK_LSB +: 2] = ready_q;
    end

    // Read data is snapshotted in the waitrequest cycle and held afterwards.
    assign rd_start = avs_read && !rd_ack_q;

    always_comb begin
        rd_ack_d = rd_start;
        rd_win_d = rd_win_q;
        rd_reg_d = rd_reg_q;
        if (rd_start) begin
            rd_win_d = win_sel && win_in_range && ready_q[rd_bank_q];
            rd_reg_d = '0;
            if (!win_sel) begin
                case (reg_off)
                    REG_CTRL:   rd_reg_d = {30'd0, ctrl_q};
                    REG_STATUS: rd_reg_d = status;
                    REG_FILL:   rd_reg_d = 32'(fill_q);
                    REG_DROPS:  rd_reg_d = {16'd0, drops_q};
                    default:    rd_reg_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            ovf_q      <= 1'b0;
            drops_q    <= '0;
            ready_q    <= '0;
            rd_bank_q  <= 1'b0;
            cap_bank_q <= 1'b0;
            fill_q     <= '0;
            irq_q      <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_win_q   <= 1'b0;
            rd_reg_q   <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            ovf_q      <= ovf_d;
            drops_q    <= drops_d;
            ready_q    <= ready_d;
            rd_bank_q  <= rd_bank_d;
            cap_bank_q <= cap_bank_d;
            fill_q     <= fill_d;
            irq_q      <= irq_d;
            rd_ack_q   <= rd_ack_d;
            rd_win_q   <= rd_win_d;
            rd_reg_q   <= rd_reg_d;
        end
    end

    afb_sample_ram #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .S_W      (S_W),
        .CH_W     (CH_W)
    ) u_ram (
        .clk       (clk),
        .wr_en     (ram_we),
        .wr_bank   (cap_bank_q),
        .wr_sample (fill_q),
        .wr_data   (snk_data),
        .rd_en     (rd_start && win_sel),
        .rd_bank   (rd_bank_q),
        .rd_sample (win_sample),
        .rd_ch     (win_ch),
        .rd_data   (ram_rd_data)
    );

    assign snk_ready       = (state_q != IDLE);
    assign irq             = irq_q;
    assign avs_waitrequest = avs_read && !rd_ack_q && !reset;
    assign avs_readdata    = rd_win_q ? sext(32'(ram_rd_data), DATA_W) : rd_reg_q;

endmodule

// File: tb/tb_audio_frame_buffer_avalon.sv
// Randomized directed bench for audio_frame_buffer_avalon against a
// frame-queue reference model (DATA_W=16, CHANNELS=2, DEPTH=8).
module tb_audio_frame_buffer_avalon;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int DP = 8;
    localparam int AW = 5;
    localparam int NW = CH * DP;

    logic          clk = 1'b0;
    logic          reset;
    logic          snk_valid;
    logic [CH*DW-1:0] snk_data;
    logic          snk_ready;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic          irq;

    always #5 clk = ~clk;

    audio_frame_buffer_avalon #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .DEPTH    (DP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .snk_valid       (snk_valid),
        .snk_data        (snk_data),
        .snk_ready       (snk_ready),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .irq             (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: completed frames queued in order of completion.
    logic [31:0] m_frame [2][NW];
    logic [31:0] m_part  [NW];
    int          m_q[$];
    int          m_fill, m_cap, m_last, m_drops;
    bit          m_ovf, m_en, m_irqen, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_fill = 0; m_cap = 0; m_last = 0; m_drops = 0;
        m_ovf = 0; m_en = 0; m_irqen = 0; m_stall = 0;
    endtask

    function automatic bit m_has(input int b);
        foreach (m_q[i]) if (m_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_q.size() > 0);
        s[1] = m_ovf;
        s[2] = (m_q.size() > 0) ? m_q[0][0] : m_last[0];
        s[8] = m_has(0);
        s[9] = m_has(1);
        return s;
    endfunction

    function automatic logic [31:0] m_window(input int idx);
        if (m_q.size() == 0) return 32'd0;
        return m_frame[m_q[0]][idx];
    endfunction

    task automatic m_ctrl(input logic [31:0] d);
        m_irqen = d[1];
        if (d[0] && !m_en) begin
            m_fill = 0;
            if (m_q.size() == 2) m_stall = 1;
            else begin
                m_stall = 0;
                if (m_has(m_cap)) m_cap = 1 - m_cap;
            end
        end else if (!d[0]) begin
            m_fill = 0;
            m_stall = 0;
        end
        m_en = d[0];
    endtask

    task automatic m_ack();
        int b;
        if (m_q.size() > 0) begin
            b = m_q.pop_front();
            m_last = b;
            if (m_stall) begin
                m_stall = 0;
                m_cap = b;
            end
        end
    endtask

    task automatic m_beat(input logic [15:0] s0, input logic [15:0] s1);
        if (m_stall) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end else begin
            m_part[m_fill]      = {{16{s0[15]}}, s0};
            m_part[DP + m_fill] = {{16{s1[15]}}, s1};
            m_fill++;
            if (m_fill == DP) begin
                foreach (m_part[i]) m_frame[m_cap][i] = m_part[i];
                m_q.push_back(m_cap);
                m_fill = 0;
                if (m_q.size() < 2) m_cap = 1 - m_cap;
                else m_stall = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = a;
        #1;
        chk("waitreq_first", 32'(avs_waitrequest), 32'd1);
        tick();
        chk("waitreq_second", 32'(avs_waitrequest), 32'd0);
        d = avs_readdata;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic chk_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        chk(tag, d, exp);
        chk("irq_level", 32'(irq), 32'(m_irqen && (m_q.size() > 0)));
    endtask

    task automatic do_beat(input bit with_ack, input logic [15:0] s0, input logic [15:0] s1);
        chk("snk_ready_beat", 32'(snk_ready), 32'd1);
        snk_valid = 1'b1; snk_data = {s1, s0};
        if (with_ack) begin
            avs_write = 1'b1; avs_address = 5'd2; avs_writedata = $urandom;
        end
        tick();
        snk_valid = 1'b0; avs_write = 1'b0;
        if (with_ack) m_ack();
        m_beat(s0, s1);
    endtask

    task automatic rnd_beat();
        do_beat(1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && !snk_ready; i++) tick();
        chk("snk_ready_rise", 32'(snk_ready), 32'd1);
    endtask

    task automatic chk_frame(input string tag);
        for (int i = 0; i < NW; i++) chk_read(tag, {1'b1, 4'(i)}, m_window(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int op;
        reset = 1'b1; snk_valid = 1'b0; snk_data = '0; avs_address = '0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        m_reset();
        repeat (3) tick();
        chk("rst_snk_ready", 32'(snk_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        reset = 1'b0;
        tick();
        chk_read("status_after_reset", 5'd1, 32'd0);

        // First frame with the test-plan pattern, then check irq latency
        do_write(5'd0, 32'd3); m_ctrl(32'd3);
        wait_ready();
        for (int i = 0; i < DP; i++) do_beat(1'b0, 16'(i), 16'(16'h8000 + i));
        chk("irq_before", 32'(irq), 32'd0);
        tick();
        chk("irq_after", 32'(irq), 32'd1);
        chk_read("status_frame0", 5'd1, m_status());
        chk_read("win_word3", 5'd16 + 5'd3, 32'h00000003);
        chk_read("win_word13", 5'd16 + 5'd13, 32'hFFFF8005);
        chk_read("unused_reg", 5'd7, 32'd0);

        // Fill second bank, then overflow
        for (int i = 0; i < DP; i++) rnd_beat();
        chk_read("status_both", 5'd1, m_status());
        for (int i = 0; i < 4; i++) rnd_beat();
        chk_read("drops_four", 5'd4, 32'd4);
        chk_read("status_ovf", 5'd1, m_status());
        chk_read("fill_stall", 5'd3, 32'd0);

        // Release bank 0 while stalled; capture resumes there
        do_write(5'd2, 32'd0); m_ack();
        chk_read("status_ack", 5'd1, m_status());
        for (int i = 0; i < 3; i++) rnd_beat();
        chk_read("fill_three", 5'd3, 32'd3);
        do_write(5'd4, 32'd0); m_drops = 0; m_ovf = 0;
        chk_read("drops_clr", 5'd4, 32'd0);
        chk_read("status_clr", 5'd1, m_status());
        for (int i = 0; i < 5; i++) rnd_beat();
        chk_frame("win_bank1");

        // ACK coincident with the completing beat
        do_write(5'd2, 32'd0); m_ack();
        for (int i = 0; i < DP - 1; i++) rnd_beat();
        do_beat(1'b1, 16'($urandom), 16'($urandom));
        chk_read("drops_coinc", 5'd4, 32'd0);
        chk_read("status_coinc", 5'd1, m_status());
        chk_read("fill_coinc", 5'd3, 32'd0);
        rnd_beat();
        chk_read("fill_after_coinc", 5'd3, 32'd1);
        chk_frame("win_coinc");

        // Randomized mix of beats, releases and reads
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) rnd_beat();
            else if (op == 5) begin do_write(5'd2, $urandom); m_ack(); end
            else if (op == 6) begin
                int idx = $urandom_range(0, NW - 1);
                chk_read("rnd_window", {1'b1, 4'(idx)}, m_window(idx));
            end
            else if (op == 7) chk_read("rnd_status", 5'd1, m_status());
            else if (op == 8) chk_read("rnd_fill", 5'd3, 32'(m_fill));
            else chk_read("rnd_drops", 5'd4, 32'(m_drops));
        end

        // Disable mid-frame discards the partial frame
        while (m_q.size() > 0) begin do_write(5'd2, 32'd0); m_ack(); end
        do_write(5'd0, 32'd2); m_ctrl(32'd2);
        tick();
        do_write(5'd0, 32'd3); m_ctrl(32'd3);
        wait_ready();
        for (int i = 0; i < 5; i++) rnd_beat();
        chk_read("fill_five", 5'd3, 32'd5);
        do_write(5'd0, 32'd2); m_ctrl(32'd2);
        tick();
        chk("snk_ready_off", 32'(snk_ready), 32'd0);
        chk_read("fill_off", 5'd3, 32'd0);
        do_write(5'd0, 32'd3); m_ctrl(32'd3);
        wait_ready();
        for (int i = 0; i < DP; i++) rnd_beat();
        chk_read("status_reen", 5'd1, m_status());
        chk_frame("win_reen");

        // Reset during a pending read
        avs_read = 1'b1; avs_address = 5'd1;
        #1;
        chk("waitreq_pre_rst", 32'(avs_waitrequest), 32'd1);
        reset = 1'b1;
        #1;
        chk("waitreq_in_rst", 32'(avs_waitrequest), 32'd0);
        avs_read = 1'b0;
        m_reset();
        tick();
        chk("rst2_snk_ready", 32'(snk_ready), 32'd0);
        chk("rst2_irq", 32'(irq), 32'd0);
        chk("rst2_readdata", avs_readdata, 32'd0);
        reset = 1'b0;
        tick();
        chk_read("rst2_ctrl", 5'd0, 32'd0);
        chk_read("rst2_status", 5'd1, 32'd0);
        chk_read("rst2_fill", 5'd3, 32'd0);
        chk_read("rst2_drops", 5'd4, 32'd0);
        chk_read("rst2_window", 5'd16, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
